pcm_frame_buffer: RTL and testbench
===================================

PCM_FRAME_BUFFER -- requirements
Module: pcm_frame_buffer

Interface
REQ-001 Parameter DATA_W, default 16, sample width; matches the final FIR output width.
REQ-002 Parameter DEPTH, default 16, FIFO depth in samples; power of two, minimum 4.
REQ-003 Parameter FRAME_LEN, default 64, samples per output frame; minimum 2.
REQ-004 clk  input  1  the one clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset: asserted when 0, released synchronously to clk.
REQ-006 en  input  1  capture enable.
REQ-007 in_valid  input  1  one-cycle strobe: in_data holds a new decimated sample.
REQ-008 in_data  input  DATA_W  signed two's-complement sample from the FIR stage.
REQ-009 out_valid  output  1  out_data, out_sof, out_eof and out_pad are valid.
REQ-010 out_ready  input  1  consumer accepts the word.
REQ-011 out_data  output  DATA_W  head sample, or zero when padding.
REQ-012 out_sof / out_eof  output  1 each  first / last word of a frame.
REQ-013 out_pad  output  1  word is zero padding, not a captured sample.
REQ-014 level  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-015 drop_cnt  output  8  saturating count of dropped samples.
REQ-016 clr_drop  input  1  synchronous clear of drop_cnt; has priority over an increment in the same cycle.

Function
REQ-017 A handshake (beat) SHALL occur on a cycle with out_valid=1 and out_ready=1; out_valid=0 otherwise implies no transfer.
REQ-018 While out_valid=1 and out_ready=0, out_data, out_sof, out_eof and out_pad SHALL hold stable.
REQ-019 The FSM SHALL have three states: IDLE, RUN and PAD.
REQ-020 IDLE: writes are ignored; out_valid=0; go to RUN on en=1.
REQ-021 RUN: a write is accepted when in_valid=1 and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-022 RUN: a write with the FIFO full and no pop SHALL be dropped, and drop_cnt SHALL increment, saturating at 255.
REQ-023 RUN: when en=0, go to PAD if frame index is nonzero or the FIFO is nonempty; otherwise go to IDLE.
REQ-024 PAD: writes are ignored; FIFO contents are output first; if the FIFO is empty and the frame is incomplete, out_valid=1, out_data=0 and out_pad=1.
REQ-025 PAD: on the out_eof beat, go to IDLE only if the FIFO is empty; otherwise stay in PAD and continue frames.
REQ-026 The FIFO SHALL be first-word-fall-through: a sample written at edge N is visible with out_valid=1 after edge N, one-cycle latency.
REQ-027 The frame index SHALL run 0..FRAME_LEN-1, advance on each beat, and wrap to 0 after FRAME_LEN-1.
REQ-028 out_sof SHALL equal (index==0), and out_eof SHALL equal (index==FRAME_LEN-1).
REQ-029 In RUN, out_valid SHALL equal FIFO-not-empty.
REQ-030 level SHALL update in the same cycle as the push/pop: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-031 Read and write pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH; full is level==DEPTH and empty is level==0.
REQ-032 Samples SHALL pass bit-exact, with no scaling or reordering.

Reset
REQ-033 Reset assertion SHALL act immediately, including mid-frame or mid-stall, with no clock required.
REQ-034 Reset SHALL set state=IDLE, pointers=0, level=0, index=0 and drop_cnt=0.
REQ-035 Reset SHALL set out_valid=0, out_sof=0, out_eof=0, out_pad=0 and out_data=0.
REQ-036 FIFO storage need not be cleared by reset.
REQ-037 The first cycle after reset release SHALL evaluate en normally.

Verification
REQ-038 Stream: en=1, out_ready=1, 128 samples 0..127 on in_valid every 8th cycle -> words 0..127 in order, each one cycle after its write; sof on values 0 and 64; eof on values 63 and 127; drop_cnt=0.
REQ-039 Overflow: en=1, out_ready=0, 20 strobes -> level=16 and drop_cnt=4; then out_ready=1 -> exactly the first 16 samples emerge.
REQ-040 Full plus simultaneous pop: level=16, in_valid and beat in the same cycle -> sample accepted, level stays 16, drop_cnt unchanged.
REQ-041 Stop mid-frame: 10 samples delivered, then en=0 -> 10 real words, then 54 words with out_data=0 and out_pad=1, eof on the 64th word, state IDLE.
REQ-042 Reset mid-stall: level=5, out_ready=0, rst=0 between edges -> out_valid=0 and level=0 immediately; after release with en=1, the next sample gets out_sof=1.
REQ-043 Saturation: 300 drops -> drop_cnt=255; clr_drop with a coincident drop -> drop_cnt=0.

Source files
------------

// File: rtl/pcm_frame_buffer_if.sv
// Sample-in / framed-word-out stream bundle for pcm_frame_buffer.
// The buffer uses the slave view; whatever feeds samples and drains frames uses master.
interface pcm_frame_buffer_if #(
   parameter int DATA_W = 16
) ();
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_sof;
   logic              out_eof;
   logic              out_pad;

   modport slave (
      input  in_valid, in_data, out_ready,
      output out_valid, out_data, out_sof, out_eof, out_pad
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  out_valid, out_data, out_sof, out_eof, out_pad
   );
endinterface

// File: rtl/pcm_frame_buffer.sv
// First-word-fall-through sample FIFO that slices the decimated PCM stream into
// fixed-length frames and zero-pads the final frame once capture is stopped.
module pcm_frame_buffer #(
   parameter int DATA_W    = 16,
   parameter int DEPTH     = 16,
   parameter int FRAME_LEN = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clr_drop,
   pcm_frame_buffer_if.slave      bus,
   output logic [$clog2(DEPTH):0] level,
   output logic [7:0]             drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int IW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PAD  = 2'd2
   } state_t;

   function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
      if (idx == LAST_IDX) begin
         idx_inc = {IW{1'b0}};
      end else begin
         idx_inc = idx + IW'(1);
      end
   endfunction

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [LW-1:0]     level_r;
   logic [IW-1:0]     idx_r;
   logic [7:0]        drop_cnt_r;
   state_t            state_r;
   logic              out_valid_r;
   logic [DATA_W-1:0] out_data_r;
   logic              out_sof_r;
   logic              out_eof_r;
   logic              out_pad_r;

   logic              beat_s;
   logic              pop_s;
   logic              full_s;
   logic              run_s;
   logic              push_s;
   logic              drop_s;
   logic [AW-1:0]     rd_ptr_nxt_s;
   logic [LW-1:0]     level_nxt_s;
   logic [IW-1:0]     idx_nxt_s;
   logic              has_data_s;
   logic [DATA_W-1:0] head_nxt_s;
   logic              pend_s;
   logic              sof_nxt_s;
   logic              eof_nxt_s;

   // Handshake decode and post-edge FIFO/frame view used to pre-register the output word.
   always_comb begin
      beat_s       = out_valid_r & bus.out_ready;
      pop_s        = beat_s & ~out_pad_r;
      full_s       = (level_r == FULL_LVL);
      run_s        = (state_r == RUN);
      push_s       = run_s & bus.in_valid & (~full_s | pop_s);
      drop_s       = run_s & bus.in_valid & full_s & ~pop_s;
      rd_ptr_nxt_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
      if (push_s && !pop_s) begin
         level_nxt_s = level_r + LW'(1);
      end else if (pop_s && !push_s) begin
         level_nxt_s = level_r - LW'(1);
      end else begin
         level_nxt_s = level_r;
      end
      if (beat_s) begin
         idx_nxt_s = idx_inc(idx_r);
      end else begin
         idx_nxt_s = idx_r;
      end
      has_data_s = (level_nxt_s != {LW{1'b0}});
      // A sample landing in the slot that becomes the head must bypass the array.
      if (!has_data_s) begin
         head_nxt_s = {DATA_W{1'b0}};
      end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
         head_nxt_s = bus.in_data;
      end else begin
         head_nxt_s = mem_r[rd_ptr_nxt_s];
      end
      pend_s    = has_data_s | (idx_nxt_s != {IW{1'b0}});
      sof_nxt_s = (idx_nxt_s == {IW{1'b0}});
      eof_nxt_s = (idx_nxt_s == LAST_IDX);
   end

   // Sample storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= bus.in_data;
      end
   end

   // Control FSM with FIFO pointers, frame index, drop counter and registered output word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         wr_ptr_r    <= {AW{1'b0}};
         rd_ptr_r    <= {AW{1'b0}};
         level_r     <= {LW{1'b0}};
         idx_r       <= {IW{1'b0}};
         drop_cnt_r  <= 8'd0;
         out_valid_r <= 1'b0;
         out_data_r  <= {DATA_W{1'b0}};
         out_sof_r   <= 1'b0;
         out_eof_r   <= 1'b0;
         out_pad_r   <= 1'b0;
      end else begin
         wr_ptr_r <= push_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
         rd_ptr_r <= rd_ptr_nxt_s;
         level_r  <= level_nxt_s;
         idx_r    <= idx_nxt_s;
         if (clr_drop) begin
            drop_cnt_r <= 8'd0;
         end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
         end else begin
            drop_cnt_r <= drop_cnt_r;
         end
         case (state_r)
            RUN: begin
               if (en) begin
                  state_r     <= RUN;
                  out_valid_r <= has_data_s;
                  out_data_r  <= head_nxt_s;
                  out_sof_r   <= has_data_s & sof_nxt_s;
                  out_eof_r   <= has_data_s & eof_nxt_s;
                  out_pad_r   <= 1'b0;
               end else if (pend_s) begin
                  state_r     <= PAD;
                  out_valid_r <= 1'b1;
                  out_data_r  <= head_nxt_s;
                  out_sof_r   <= sof_nxt_s;
                  out_eof_r   <= eof_nxt_s;
                  out_pad_r   <= ~has_data_s;
               end else begin
                  state_r     <= IDLE;
                  out_valid_r <= 1'b0;
                  out_data_r  <= {DATA_W{1'b0}};
                  out_sof_r   <= 1'b0;
                  out_eof_r   <= 1'b0;
                  out_pad_r   <= 1'b0;
               end
            end
            PAD: begin
               // Leave only once the frame has closed with nothing left buffered.
               if (pend_s) begin
                  state_r     <= PAD;
                  out_valid_r <= 1'b1;
                  out_data_r  <= head_nxt_s;
                  out_sof_r   <= sof_nxt_s;
                  out_eof_r   <= eof_nxt_s;
                  out_pad_r   <= ~has_data_s;
               end else begin
                  state_r     <= IDLE;
                  out_valid_r <= 1'b0;
                  out_data_r  <= {DATA_W{1'b0}};
                  out_sof_r   <= 1'b0;
                  out_eof_r   <= 1'b0;
                  out_pad_r   <= 1'b0;
               end
            end
            default: begin
               state_r     <= en ? RUN : IDLE;
               out_valid_r <= 1'b0;
               out_data_r  <= {DATA_W{1'b0}};
               out_sof_r   <= 1'b0;
               out_eof_r   <= 1'b0;
               out_pad_r   <= 1'b0;
            end
         endcase
      end
   end

   assign level         = level_r;
   assign drop_cnt      = drop_cnt_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_sof   = out_sof_r;
   assign bus.out_eof   = out_eof_r;
   assign bus.out_pad   = out_pad_r;

endmodule

// File: tb/tb_pcm_frame_buffer.sv
// Scoreboard bench for pcm_frame_buffer: stimulus queues expected words, a negedge
// monitor pops and compares them on every output beat.
module tb_pcm_frame_buffer;
   localparam int DATA_W    = 16;
   localparam int DEPTH     = 16;
   localparam int FRAME_LEN = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       clr_drop;
   logic [4:0] level;
   logic [7:0] drop_cnt;

   pcm_frame_buffer_if #(.DATA_W(DATA_W)) bus ();

   pcm_frame_buffer #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .FRAME_LEN(FRAME_LEN)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .clr_drop(clr_drop),
      .bus     (bus),
      .level   (level),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        pad;
      logic        lat;
      int          wcyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_mon;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   int   beat_idx = 0;
   int   n_beats  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Output monitor: every beat must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("queue_nonempty_at_beat", exp_q.size(), 1);
         end else begin
            e_mon = exp_q.pop_front();
            check("beat_word",
                  {bus.out_data, bus.out_pad, bus.out_sof, bus.out_eof},
                  {e_mon.data, e_mon.pad, (beat_idx == 0), (beat_idx == FRAME_LEN - 1)});
            if (e_mon.lat) check("beat_latency", cyc, e_mon.wcyc + 1);
            beat_idx = (beat_idx + 1) % FRAME_LEN;
            n_beats++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b0;
      en           = 1'b0;
      clr_drop     = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 16'h0000;
      bus.out_ready = 1'b0;
      repeat (2) tick();
      exp_q.delete();
      beat_idx = 0;
      n_beats  = 0;
      rst      = 1'b1;
      tick();
   endtask

   task automatic write(input logic [15:0] v, input bit expect_it, input bit lat);
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      if (expect_it) exp_q.push_back('{v, 1'b0, lat, cyc});
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         tick();
         n++;
      end
      check("drain_done", exp_q.size(), 0);
   endtask

   logic [15:0] mid_vals [10] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h1234,
                                  16'hEDCB, 16'h00FF, 16'hFF00, 16'h5A5A, 16'hA5A5};

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b0;
      en           = 1'b0;
      clr_drop     = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 16'h0000;
      bus.out_ready = 1'b0;
      repeat (2) tick();
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_flags", {bus.out_sof, bus.out_eof, bus.out_pad}, 3'b000);
      check("rst_data", bus.out_data, 16'h0000);
      check("rst_level", level, 0);
      check("rst_drop", drop_cnt, 0);
      rst = 1'b1;
      tick();

      // Stream of 128 samples, one every 8th cycle.
      en = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      for (int v = 0; v < 128; v++) begin
         write(16'(v), 1'b1, 1'b1);
         repeat (7) tick();
      end
      drain(20);
      check("stream_beats", n_beats, 128);
      check("stream_level", level, 0);
      check("stream_drop", drop_cnt, 0);

      // Overflow with stalled consumer, then full-plus-pop.
      do_reset();
      en = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) write(16'(100 + i), (i < 16), 1'b0);
      check("ovf_level", level, 16);
      check("ovf_drop", drop_cnt, 4);
      check("ovf_valid_held", {bus.out_valid, bus.out_data}, {1'b1, 16'd100});
      bus.out_ready = 1'b1;
      write(16'd500, 1'b1, 1'b0);
      bus.out_ready = 1'b0;
      check("fullpop_level", level, 16);
      check("fullpop_drop", drop_cnt, 4);
      bus.out_ready = 1'b1;
      drain(40);
      check("ovf_beats", n_beats, 17);
      tick();
      check("ovf_empty_level", level, 0);
      check("ovf_empty_valid", bus.out_valid, 0);

      // Stop mid-frame after 10 samples: remainder of the frame is padding.
      do_reset();
      en = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         write(mid_vals[i], 1'b1, 1'b1);
         repeat (2) tick();
      end
      for (int i = 0; i < 54; i++) exp_q.push_back('{16'h0000, 1'b1, 1'b0, 0});
      en = 1'b0;
      drain(80);
      check("pad_total_beats", n_beats, 64);
      repeat (3) tick();
      check("pad_idle_valid", bus.out_valid, 0);
      write(16'h5555, 1'b0, 1'b0);
      tick();
      check("pad_idle_level", level, 0);
      check("pad_idle_valid2", bus.out_valid, 0);

      // Asynchronous reset while stalled with five samples buffered.
      do_reset();
      en = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) write(16'(200 + i), 1'b0, 1'b0);
      check("stall_level", level, 5);
      check("stall_valid", bus.out_valid, 1);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_valid", bus.out_valid, 0);
      check("async_rst_level", level, 0);
      exp_q.delete();
      beat_idx = 0;
      n_beats  = 0;
      tick();
      rst = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      write(16'h1234, 1'b1, 1'b1);
      drain(10);
      check("post_rst_beats", n_beats, 1);

      // Drop counter saturation and clear priority.
      do_reset();
      en = 1'b1;
      tick();
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0042;
      repeat (316) tick();
      bus.in_valid = 1'b0;
      check("sat_drop", drop_cnt, 255);
      check("sat_level", level, 16);
      clr_drop     = 1'b1;
      bus.in_valid = 1'b1;
      tick();
      clr_drop     = 1'b0;
      check("clr_priority", drop_cnt, 0);
      tick();
      bus.in_valid = 1'b0;
      check("drop_after_clr", drop_cnt, 1);

      do_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
